// File: rtl/mapa_pkg.sv
// Shared definitions for the game map: cell codes, cell bit-fields,
// map geometry defaults and the map arbiter state encoding.
package mapa_pkg;

    localparam int MAPA_WIDTH_DEF  = 40;
    localparam int MAPA_HEIGHT_DEF = 30;
    localparam int CELL_W_DEF      = 4;
    localparam int COORD_W         = 10;

    typedef enum logic [3:0] {
        NADA      = 4'd0,
        COBRA     = 4'd1,
        FRUTA     = 4'd2,
        OBSTACULO = 4'd3
    } cell_t;

    // Snake body cells: flag bit marks a segment, id bit picks the snake,
    // the low field holds the direction towards the tail.
    localparam int CELL_SNAKE_BIT = 3;
    localparam int CELL_ID_BIT    = 2;
    localparam int CELL_DIR_LSB   = 0;
    localparam int CELL_DIR_W     = 2;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

endpackage

// File: rtl/mapa_arbitro_if.sv
// Requester-side handshake bus of the map arbiter: per-requester commands
// in, one-hot grant / read-valid and shared read data out.
interface mapa_arbitro_if #(
    parameter int N_REQ  = 3,
    parameter int CELL_W = 4
);
    import mapa_pkg::*;

    logic [N_REQ-1:0]         req;
    logic [N_REQ-1:0]         we;
    logic [N_REQ*COORD_W-1:0] req_x;
    logic [N_REQ*COORD_W-1:0] req_y;
    logic [N_REQ*CELL_W-1:0]  req_wdata;
    logic [N_REQ-1:0]         gnt;
    logic [N_REQ-1:0]         rvalid;
    logic [CELL_W-1:0]        rdata;

    modport master (
        output req, we, req_x, req_y, req_wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, req_x, req_y, req_wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/rr_arbitro.sv
// N-way round-robin picker: grants the first request at or after the
// pointer (wrapping) and returns the pointer just past the winner.
module rr_arbitro #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] next_ptr
);

    logic found;
    int   idx;

    always_comb begin
        gnt      = '0;
        next_ptr = ptr;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                next_ptr = PW'((idx + 1) % N);
            end
        end
    end

endmodule

// File: rtl/mapa_arbitro.sv
// Single owner of the map memory port: VGA reads first, then the clear
// sweep, then round-robin game-logic requesters.
module mapa_arbitro
    import mapa_pkg::*;
#(
    parameter int MAPA_WIDTH  = MAPA_WIDTH_DEF,
    parameter int MAPA_HEIGHT = MAPA_HEIGHT_DEF,
    parameter int N_REQ       = 3,
    parameter int CELL_W      = CELL_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    output logic               busy,
    input  logic               vga_read,
    input  logic [COORD_W-1:0] vga_x,
    input  logic [COORD_W-1:0] vga_y,
    output logic               vga_rvalid,
    output logic [CELL_W-1:0]  vga_rdata,
    mapa_arbitro_if.slave      bus,
    output logic               mem_en,
    output logic               mem_we,
    output logic [COORD_W-1:0] mem_x,
    output logic [COORD_W-1:0] mem_y,
    output logic [CELL_W-1:0]  mem_wdata,
    input  logic [CELL_W-1:0]  mem_rdata
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [COORD_W-1:0] X_LIM  = COORD_W'(MAPA_WIDTH);
    localparam logic [COORD_W-1:0] Y_LIM  = COORD_W'(MAPA_HEIGHT);
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(MAPA_WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(MAPA_HEIGHT - 1);

    state_t             state, state_d;
    logic [COORD_W-1:0] sweep_x, sweep_y, sweep_x_d, sweep_y_d;
    logic [PW-1:0]      ptr, ptr_d, rr_next;
    logic [N_REQ-1:0]   rr_gnt;
    logic               vga_pend, vga_oor;
    logic [N_REQ-1:0]   rd_pend;
    logic               rd_oor;
    logic               vga_ok, sel_ok, sel_we, serve_slot;
    logic [COORD_W-1:0] sel_x, sel_y;
    logic [CELL_W-1:0]  sel_wdata;

    rr_arbitro #(.N(N_REQ), .PW(PW)) u_rr (
        .req      (bus.req),
        .ptr      (ptr),
        .gnt      (rr_gnt),
        .next_ptr (rr_next)
    );

    assign vga_ok     = (vga_x < X_LIM) && (vga_y < Y_LIM);
    assign serve_slot = (state == ST_SERVE) && !vga_read && !reset;
    assign bus.gnt    = serve_slot ? rr_gnt : '0;

    always_comb begin
        sel_we    = 1'b0;
        sel_x     = '0;
        sel_y     = '0;
        sel_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (rr_gnt[i]) begin
                sel_we    = bus.we[i];
                sel_x     = bus.req_x[i*COORD_W +: COORD_W];
                sel_y     = bus.req_y[i*COORD_W +: COORD_W];
                sel_wdata = bus.req_wdata[i*CELL_W +: CELL_W];
            end
        end
    end

    assign sel_ok = (sel_x < X_LIM) && (sel_y < Y_LIM);

    // Out-of-range accesses keep their slot but never touch the memory.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_x     = '0;
        mem_y     = '0;
        mem_wdata = '0;
        if (!reset) begin
            if (vga_read) begin
                mem_en = vga_ok;
                mem_x  = vga_x;
                mem_y  = vga_y;
            end else if (state == ST_CLEAR) begin
                mem_en = 1'b1;
                mem_we = 1'b1;
                mem_x  = sweep_x;
                mem_y  = sweep_y;
            end else if (|rr_gnt) begin
                mem_en    = sel_ok;
                mem_we    = sel_we && sel_ok;
                mem_x     = sel_x;
                mem_y     = sel_y;
                mem_wdata = sel_wdata;
            end
        end
    end

    always_comb begin
        state_d   = state;
        sweep_x_d = sweep_x;
        sweep_y_d = sweep_y;
        ptr_d     = ptr;
        if (|bus.gnt) begin
            ptr_d = rr_next;
        end
        if (clear) begin
            state_d   = ST_CLEAR;
            sweep_x_d = '0;
            sweep_y_d = '0;
        end else if (state == ST_CLEAR && !vga_read) begin
            if (sweep_x == X_LAST) begin
                sweep_x_d = '0;
                if (sweep_y == Y_LAST) begin
                    sweep_y_d = '0;
                    state_d   = ST_SERVE;
                end else begin
                    sweep_y_d = sweep_y + COORD_W'(1);
                end
            end else begin
                sweep_x_d = sweep_x + COORD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_CLEAR;
            sweep_x  <= '0;
            sweep_y  <= '0;
            ptr      <= '0;
            vga_pend <= 1'b0;
            vga_oor  <= 1'b0;
            rd_pend  <= '0;
            rd_oor   <= 1'b0;
        end else begin
            state    <= state_d;
            sweep_x  <= sweep_x_d;
            sweep_y  <= sweep_y_d;
            ptr      <= ptr_d;
            vga_pend <= vga_read;
            vga_oor  <= !vga_ok;
            rd_pend  <= (|bus.gnt && !sel_we) ? bus.gnt : '0;
            rd_oor   <= !sel_ok;
        end
    end

    assign busy       = (state == ST_CLEAR);
    assign vga_rvalid = vga_pend;
    assign vga_rdata  = (vga_pend && !vga_oor) ? mem_rdata : '0;
    assign bus.rvalid = rd_pend;
    assign bus.rdata  = (|rd_pend && !rd_oor) ? mem_rdata : '0;

endmodule

// File: tb/tb_mapa_arbitro.sv
// Scoreboard bench for mapa_arbitro: directed stimulus pushes expected
// commands/responses, a negedge monitor pops and compares them.
module tb_mapa_arbitro;
    import mapa_pkg::*;

    localparam int N = 3, CW = 4, W = 40, H = 30;

    typedef struct { int cyc; logic [2:0] gnt; logic en; logic we;
                     logic [9:0] x; logic [9:0] y; logic [3:0] wdata; } cmd_t;
    typedef struct { int cyc; logic [2:0] rv; logic [3:0] data; } rd_t;
    typedef struct { int cyc; logic [3:0] data; } vga_t;
    typedef struct { logic [9:0] x; logic [9:0] y; } sw_t;

    logic       clk = 1'b0, reset = 1'b1, clear = 1'b0, busy;
    logic       vga_read = 1'b0, vga_rvalid;
    logic [9:0] vga_x = '0, vga_y = '0;
    logic [3:0] vga_rdata;
    logic       mem_en, mem_we;
    logic [9:0] mem_x, mem_y;
    logic [3:0] mem_wdata;
    logic [3:0] mem_rdata = 4'h0;
    logic       mem_ready = 1'b0;
    logic [3:0] map_mem [0:H-1][0:W-1];

    int checks = 0, failures = 0, cyc = 0;
    cmd_t cmd_q[$];
    rd_t  rd_q[$];
    vga_t vga_q[$];
    sw_t  sw_q[$];

    mapa_arbitro_if #(.N_REQ(N), .CELL_W(CW)) bus ();

    mapa_arbitro #(.MAPA_WIDTH(W), .MAPA_HEIGHT(H), .N_REQ(N), .CELL_W(CW)) dut (
        .clk(clk), .reset(reset), .clear(clear), .busy(busy),
        .vga_read(vga_read), .vga_x(vga_x), .vga_y(vga_y),
        .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
        .bus(bus),
        .mem_en(mem_en), .mem_we(mem_we), .mem_x(mem_x), .mem_y(mem_y),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Map storage: filled with a nonzero pattern so a missed clear is visible.
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++)
                    map_mem[y][x] <= 4'hF;
            mem_ready <= 1'b1;
        end else if (mem_en && mem_x < 10'(W) && mem_y < 10'(H)) begin
            if (mem_we) map_mem[mem_y][mem_x] <= mem_wdata;
            else        mem_rdata <= map_mem[mem_y][mem_x];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flagUnexpected(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: got unexpected output expected none (cycle %0d)", name, cyc);
    endtask

    // Monitor: pops the matching queue whenever the DUT presents something.
    always @(negedge clk) begin
        if (!reset) begin
            if (|bus.gnt || (mem_en && !mem_we)) begin
                if (cmd_q.size() == 0) flagUnexpected("cmd");
                else begin
                    cmd_t e;
                    e = cmd_q.pop_front();
                    checkOutput("cmd_cycle", cyc, e.cyc);
                    checkOutput("cmd_gnt", 32'(bus.gnt), 32'(e.gnt));
                    checkOutput("cmd_en", 32'(mem_en), 32'(e.en));
                    if (e.en) begin
                        checkOutput("cmd_we", 32'(mem_we), 32'(e.we));
                        checkOutput("cmd_x", 32'(mem_x), 32'(e.x));
                        checkOutput("cmd_y", 32'(mem_y), 32'(e.y));
                        if (e.we) checkOutput("cmd_wdata", 32'(mem_wdata), 32'(e.wdata));
                    end
                end
            end else if (mem_en && mem_we) begin
                if (sw_q.size() == 0) flagUnexpected("sweep");
                else begin
                    sw_t s;
                    s = sw_q.pop_front();
                    checkOutput("sweep_x", 32'(mem_x), 32'(s.x));
                    checkOutput("sweep_y", 32'(mem_y), 32'(s.y));
                    checkOutput("sweep_wdata", 32'(mem_wdata), 32'(0));
                end
            end
            if (bus.rvalid != 3'b000) begin
                if (rd_q.size() == 0) flagUnexpected("rvalid");
                else begin
                    rd_t r;
                    r = rd_q.pop_front();
                    checkOutput("rd_cycle", cyc, r.cyc);
                    checkOutput("rd_rvalid", 32'(bus.rvalid), 32'(r.rv));
                    checkOutput("rd_rdata", 32'(bus.rdata), 32'(r.data));
                end
            end
            if (vga_rvalid) begin
                if (vga_q.size() == 0) flagUnexpected("vga_rvalid");
                else begin
                    vga_t v;
                    v = vga_q.pop_front();
                    checkOutput("vga_cycle", cyc, v.cyc);
                    checkOutput("vga_rdata", 32'(vga_rdata), 32'(v.data));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int i, input logic r, input logic w,
                                 input int x, input int y, input int d);
        bus.req[i]             = r;
        bus.we[i]              = w;
        bus.req_x[i*10 +: 10]  = 10'(x);
        bus.req_y[i*10 +: 10]  = 10'(y);
        bus.req_wdata[i*4 +: 4] = 4'(d);
    endtask

    task automatic pushCmd(input int c, input logic [2:0] g, input logic en, input logic we,
                           input int x, input int y, input int d);
        cmd_q.push_back('{c, g, en, we, 10'(x), 10'(y), 4'(d)});
    endtask

    task automatic pushRd(input int c, input logic [2:0] rv, input int d);
        rd_q.push_back('{c, rv, 4'(d)});
    endtask

    task automatic pushVga(input int c, input int d);
        vga_q.push_back('{c, 4'(d)});
    endtask

    task automatic pushSweep(input int n);
        for (int k = 0; k < n; k++) sw_q.push_back('{10'(k % W), 10'(k / W)});
    endtask

    // Round-robin writers: requester i writes 3+2i at (20+i, 1).
    task automatic pushGrant(input int c, input int idx);
        pushCmd(c, 3'(1 << idx), 1'b1, 1'b1, 20 + idx, 1, 3 + 2 * idx);
    endtask

    task automatic runSweepEnd();
        repeat (1199) step();
        @(negedge clk) checkOutput("busy_last_sweep_cycle", 32'(busy), 32'(1));
        step();
        @(negedge clk) checkOutput("busy_after_sweep", 32'(busy), 32'(0));
        step();
    endtask

    initial begin
        int seq1[6] = '{0, 1, 2, 0, 1, 2};
        int seq2[3] = '{0, 2, 0};
        int vx[4]   = '{0, 5, 20, 21};
        int vy[4]   = '{0, 7, 1, 1};
        int vd[4]   = '{0, 2, 3, 5};

        bus.req = '0; bus.we = '0; bus.req_x = '0; bus.req_y = '0; bus.req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'(1));
        checkOutput("reset_gnt", 32'(bus.gnt), 32'(0));
        checkOutput("reset_rvalid", 32'(bus.rvalid), 32'(0));
        checkOutput("reset_vga_rvalid", 32'(vga_rvalid), 32'(0));
        checkOutput("reset_mem_en", 32'(mem_en), 32'(0));
        checkOutput("reset_mem_we", 32'(mem_we), 32'(0));
        checkOutput("reset_rdata", 32'(bus.rdata), 32'(0));
        checkOutput("reset_vga_rdata", 32'(vga_rdata), 32'(0));

        // Initial sweep after reset.
        pushSweep(W * H);
        @(posedge clk);
        #1 reset = 1'b0;
        runSweepEnd();

        // Round robin with all three requesting, then 101.
        for (int i = 0; i < N; i++) applyStimulus(i, 1'b1, 1'b1, 20 + i, 1, 3 + 2 * i);
        for (int j = 0; j < 6; j++) pushGrant(cyc + j, seq1[j]);
        repeat (6) step();
        bus.req = 3'b101;
        for (int j = 0; j < 3; j++) pushGrant(cyc + j, seq2[j]);
        repeat (3) step();
        bus.req = '0;

        // Requester 1 writes then reads back (5,7).
        applyStimulus(1, 1'b1, 1'b1, 5, 7, 2);
        pushCmd(cyc, 3'b010, 1'b1, 1'b1, 5, 7, 2);
        step();
        applyStimulus(1, 1'b1, 1'b0, 5, 7, 0);
        pushCmd(cyc, 3'b010, 1'b1, 1'b0, 5, 7, 0);
        pushRd(cyc + 1, 3'b010, 2);
        step();
        bus.req = '0;

        // VGA holds off requester 0 for four cycles.
        applyStimulus(0, 1'b1, 1'b1, 30, 20, 9);
        for (int j = 0; j < 4; j++) begin
            vga_read = 1'b1; vga_x = 10'(vx[j]); vga_y = 10'(vy[j]);
            pushCmd(cyc, 3'b000, 1'b1, 1'b0, vx[j], vy[j], 0);
            pushVga(cyc + 1, vd[j]);
            step();
        end
        vga_read = 1'b0;
        pushCmd(cyc, 3'b001, 1'b1, 1'b1, 30, 20, 9);
        step();
        bus.req = '0;

        // Out-of-range requester read, then out-of-range VGA read.
        applyStimulus(2, 1'b1, 1'b0, 40, 3, 0);
        pushCmd(cyc, 3'b100, 1'b0, 1'b0, 0, 0, 0);
        pushRd(cyc + 1, 3'b100, 0);
        step();
        bus.req = '0;
        vga_read = 1'b1; vga_x = 10'd3; vga_y = 10'd30;
        pushVga(cyc + 1, 0);
        step();
        vga_read = 1'b0;
        step();

        // Clear with a same-cycle read grant, restart mid-sweep at (12,3).
        applyStimulus(1, 1'b1, 1'b0, 5, 7, 0);
        clear = 1'b1;
        pushCmd(cyc, 3'b010, 1'b1, 1'b0, 5, 7, 0);
        pushRd(cyc + 1, 3'b010, 2);
        pushSweep(3 * W + 13);
        pushSweep(W * H);
        step();
        clear = 1'b0;
        bus.req = '0;
        @(negedge clk) checkOutput("busy_after_clear_pulse", 32'(busy), 32'(1));
        for (int k = 0; k < 3 * W + 13; k++) begin
            if (k == 20) begin
                vga_read = 1'b1; vga_x = 10'd5; vga_y = 10'd7;
                pushCmd(cyc, 3'b000, 1'b1, 1'b0, 5, 7, 0);
                pushVga(cyc + 1, 2);
                step();
                vga_read = 1'b0;
            end
            if (k == 3 * W + 12) clear = 1'b1;
            step();
            clear = 1'b0;
        end
        runSweepEnd();

        // Reset while a read is in flight drops its rvalid.
        applyStimulus(0, 1'b1, 1'b0, 0, 0, 0);
        pushCmd(cyc, 3'b001, 1'b1, 1'b0, 0, 0, 0);
        @(negedge clk);
        #2 reset = 1'b1;
        bus.req = '0;
        @(negedge clk);
        checkOutput("midreset_rvalid", 32'(bus.rvalid), 32'(0));
        checkOutput("midreset_busy", 32'(busy), 32'(1));
        checkOutput("midreset_mem_en", 32'(mem_en), 32'(0));
        pushSweep(W * H);
        @(posedge clk);
        #1 reset = 1'b0;
        runSweepEnd();

        step();
        checkOutput("cmd_q_drained", 32'(cmd_q.size()), 32'(0));
        checkOutput("rd_q_drained", 32'(rd_q.size()), 32'(0));
        checkOutput("vga_q_drained", 32'(vga_q.size()), 32'(0));
        checkOutput("sweep_q_drained", 32'(sw_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        failures++;
        $display("[TB] FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
